uart_tx_feeder: RTL

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_if.sv | 35 +++
 rtl/uart_tx_feeder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between the byte source / UART transmitter side and the
// uart_tx_feeder. The master modport is the surrounding system (byte writer
// plus transmitter); the slave modport is the feeder itself.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Host side
    logic          enable;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          clr_err;
    logic          overflow;
    logic          timeout;

    // Transmitter side
    logic [7:0]    d_out;
    logic          tx_send;
    logic          enable_tx;
    logic          sending;

    modport master (
        output enable, wr_en, wr_data, clr_err, sending,
        input  full, empty, count, overflow, timeout, d_out, tx_send, enable_tx
    );

    modport slave (
        input  enable, wr_en, wr_data, clr_err, sending,
        output full, empty, count, overflow, timeout, d_out, tx_send, enable_tx
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a level-controlled UART transmitter one frame at a
// time: pop a byte, present it on d_out, raise tx_send, wait for the
// transmitter's sending flag to rise and fall, then hold tx_send low for a
// fixed gap before the next byte. A transmitter that never starts is
// abandoned after START_TIMEOUT cycles and flagged.
module uart_tx_feeder #(
    parameter int DEPTH         = 16,   // power of 2, 2..256
    parameter int GAP_CYCLES    = 4,    // >= 1
    parameter int START_TIMEOUT = 1023  // >= 1
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_feeder_if.slave bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;

    logic [7:0]      d_out_q;
    logic            tx_send_q, tx_send_d;
    logic            enable_tx_q;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;

    logic            full, empty;
    logic            push, pop;
    logic            timeout_evt;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A pop only happens in LOAD while enabled; a write is accepted when
    // there is room or when that pop frees a slot in the same cycle.
    assign pop  = (state_q == LOAD) && bus.enable;
    assign push = bus.wr_en && (!full || pop);

    // Frame sequencing: next state and the shared gap/timeout timer.
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_evt = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) state_d = LOAD;
            end
            LOAD: begin
                state_d = ARM;
            end
            ARM: begin
                state_d = WAIT_START;
                timer_d = '0;
            end
            WAIT_START: begin
                if (bus.sending) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TO_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = GAP;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.sending) begin
                    state_d = GAP;
                    timer_d = '0;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) state_d = IDLE;
                else                     timer_d = timer_q + TW'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disabling aborts whatever is in flight; the FIFO is untouched.
        if (!bus.enable) begin
            state_d     = IDLE;
            timeout_evt = 1'b0;
        end
    end

    // State and timer registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Occupancy and sticky error flags; a set event beats clr_err.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (bus.wr_en && full && !pop) overflow_d = 1'b1;
        else if (bus.clr_err)          overflow_d = 1'b0;

        timeout_d = timeout_q;
        if (timeout_evt)      timeout_d = 1'b1;
        else if (bus.clr_err) timeout_d = 1'b0;

        // tx_send is registered from the next state so it is glitch-free
        // and lines up with the state it belongs to.
        tx_send_d = (state_d == WAIT_START) || (state_d == WAIT_DONE);
    end

    // FIFO pointers and count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; count/pointers define validity, and resetting it would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    // Output byte register; it changes only on a pop in LOAD. A simultaneous
    // push to the same slot (full FIFO) does not disturb the byte read here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   d_out_q <= 8'h00;
        else if (pop) d_out_q <= mem_q[rd_ptr_q];
    end

    // Transmitter control levels and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_send_q   <= 1'b0;
            enable_tx_q <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tx_send_q   <= tx_send_d;
            enable_tx_q <= bus.enable;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.d_out     = d_out_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.enable_tx = enable_tx_q;
    assign bus.overflow  = overflow_q;
    assign bus.timeout   = timeout_q;

endmodule
